// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch / branch-prediction slice.
// Contents:
//   OP_BEQ, OP_BNE, OP_J  - primary opcodes (ins[31:26]) that the fetch stage predecodes
//   ctr_t                 - 2-bit saturating branch-history counter
//   CTR_SNT..CTR_ST       - counter encodings, strong-not-taken up to strong-taken
//   ctr_update            - saturating counter step for a resolved branch outcome
package if_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Move the counter one step toward the observed outcome. It stops at either
  // end, so a long run of one outcome costs at most two mispredicts to reverse.
  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_predict_bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// The read is asynchronous, the write happens on the clock edge, and the
// asynchronous reset loads every entry with CTR_INIT.
// Optional build macro: IF_BHT_FWD_EN. When it is defined, a read of the entry
// being updated in the same cycle returns the post-update value. When it is
// not defined, the read returns the stored value.
// Ports:
//   clk, rst  - clock (rising edge) and asynchronous active-high reset
//   rd_idx    - read index (fetch PC)
//   rd_ctr    - counter value seen by the fetch stage
//   wr_en     - resolved conditional branch this cycle
//   wr_idx    - index of the resolved branch
//   wr_taken  - actual outcome of the resolved branch
module bht_2bit
  import if_pkg::*;
#(
  parameter int   IDX_W    = 6,
  parameter ctr_t CTR_INIT = CTR_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  ctr_t ctr_q [ENTRIES];
  ctr_t stored;

  // Counter storage. Reset reinitialises the whole table at once, so history
  // from before a reset never affects the predictions that follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], wr_taken);
    end
  end

  assign stored = ctr_q[rd_idx];

`ifdef IF_BHT_FWD_EN
  // Bypass: when fetch reads the entry that is being trained in this cycle,
  // it sees the value that will be written at the next edge.
  always_comb begin
    rd_ctr = stored;
    if (wr_en && (wr_idx == rd_idx)) rd_ctr = ctr_update(stored, wr_taken);
  end
`else
  // No bypass: fetch sees the stored value. The update takes effect at the edge.
  always_comb begin
    rd_ctr = stored;
  end
`endif

endmodule

// File: rtl/if_fetch_predict.sv
// Instruction-fetch stage. It holds the PC, predecodes the fetched word and
// predicts the next PC using a 2-bit BHT.
// Optional build macro: IF_BHT_FWD_EN (BHT same-cycle update forwarding).
// Ports:
//   clk, rst          - clock (rising edge) and asynchronous active-high reset
//   pc_write          - 1 lets the PC advance, 0 holds it (load-use stall)
//   redirect_valid/pc - recovery from EX. It has priority over a stall.
//   upd_valid/pc/taken- resolved conditional branch, used to train the BHT
//   ins               - instruction word returned by imem for imem_addr
//   imem_addr         - current PC
//   predict           - fetched beq/bne whose counter predicts taken
//   branchaddr        - pc+4 + (sext(imm16) << 2)
//   pcaddr            - pc+4
//   predictionbuffer  - BHT counter for the current PC
//   signextendresult  - sext(imm16)
module if_fetch_predict
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 6,
  parameter ctr_t        CTR_INIT  = CTR_WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] ins,
  output logic [31:0] imem_addr,
  output logic        predict,
  output logic [31:0] branchaddr,
  output logic [31:0] pcaddr,
  output logic [1:0]  predictionbuffer,
  output logic [31:0] signextendresult
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        is_br;
  logic        is_j;
  ctr_t        ctr;
  logic        unused_upd_bits;

  // Only the index bits of upd_pc address the table. The other bits are
  // deliberately ignored.
  assign unused_upd_bits = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0]};

  bht_2bit #(
    .IDX_W    (BHT_IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc[BHT_IDX_W+1:2]),
    .rd_ctr   (ctr),
    .wr_en    (upd_valid),
    .wr_idx   (upd_pc[BHT_IDX_W+1:2]),
    .wr_taken (upd_taken)
  );

  // Predecode and address generation. All of this is combinational from the
  // PC, the fetched word and the BHT, so the IF/ID register can capture it in
  // the same cycle. Address arithmetic wraps modulo 2^32.
  always_comb begin
    pcaddr           = pc + 32'd4;
    signextendresult = {{16{ins[15]}}, ins[15:0]};
    branchaddr       = pcaddr + {signextendresult[29:0], 2'b00};
    is_br            = (ins[31:26] == OP_BEQ) || (ins[31:26] == OP_BNE);
    is_j             = (ins[31:26] == OP_J);
    predict          = is_br & ctr[1];
    predictionbuffer = ctr;
    imem_addr        = pc;
  end

  // Next-PC selection. A redirect from EX wins over a stall, because the
  // instruction that caused the stall is on the wrong path anyway.
  always_comb begin
    next_pc = pcaddr;
    if (redirect_valid)  next_pc = redirect_pc;
    else if (!pc_write)  next_pc = pc;
    else if (predict)    next_pc = branchaddr;
    else if (is_j)       next_pc = {pcaddr[31:28], ins[25:0], 2'b00};
  end

  // PC register. Reset takes effect immediately and discards any redirect
  // that is pending in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_if_fetch_predict.sv
// Self-checking bench for if_fetch_predict. Expected next-PC values are pushed
// into a scoreboard queue when stimulus is driven, and popped and compared
// after the clock edge that should produce them. Combinational outputs are
// compared in the same cycle. Inputs change 1 ns after the rising edge.
module tb_if_fetch_predict;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BEQ = 32'h1000_0003;  // beq, imm = 3
  localparam logic [31:0] JMP = 32'h0800_0010;  // j, addr26 = 0x10

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] ins;
  logic [31:0] imem_addr;
  logic        predict;
  logic [31:0] branchaddr;
  logic [31:0] pcaddr;
  logic [1:0]  predictionbuffer;
  logic [31:0] signextendresult;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  if_fetch_predict dut (
    .clk              (clk),
    .rst              (rst),
    .pc_write         (pc_write),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .ins              (ins),
    .imem_addr        (imem_addr),
    .predict          (predict),
    .branchaddr       (branchaddr),
    .pcaddr           (pcaddr),
    .predictionbuffer (predictionbuffer),
    .signextendresult (signextendresult)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the PC through the redirect path.
  task automatic set_pc(input logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_write = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; ins = BEQ;
    #2;
    checks++;
    if (imem_addr !== 32'h0 || pcaddr !== 32'h4 || predictionbuffer !== 2'b01 || predict !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: addr=%h pcaddr=%h ctr=%b pred=%b want 0/4/01/0",
               imem_addr, pcaddr, predictionbuffer, predict);
    end
    ins = NOP;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) sb.push_back('{"seq_fetch", 32'(4 * i)});
    for (int i = 1; i <= 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (imem_addr !== e.value || predict !== 1'b0 || predictionbuffer !== 2'b01) begin
        errors++;
        $display("[TB] FAIL %s: addr=%h pred=%b ctr=%b want %h/0/01",
                 e.tag, imem_addr, predict, predictionbuffer, e.value);
      end
    end
  endtask

  task automatic test_branch_predict();
    set_pc(32'h10);
    ins = BEQ;
    #1;
    checks++;
    if (predict !== 1'b0 || branchaddr !== 32'h20 || pcaddr !== 32'h14 ||
        signextendresult !== 32'h3 || predictionbuffer !== 2'b01) begin
      errors++;
      $display("[TB] FAIL beq_weak_nt: pred=%b baddr=%h pcaddr=%h sext=%h ctr=%b",
               predict, branchaddr, pcaddr, signextendresult, predictionbuffer);
    end
    sb.push_back('{"beq_not_taken_next", 32'h14});
    tick();
    e = sb.pop_front();
    checks++;
    if (imem_addr !== e.value) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", e.tag, imem_addr, e.value);
    end
    // Train index 4 twice while fetch sits at 0x14 (index 5).
    ins = NOP; pc_write = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    tick(); tick();
    upd_valid = 1'b0; pc_write = 1'b1;
    set_pc(32'h10);
    ins = BEQ;
    #1;
    checks++;
    if (predict !== 1'b1 || predictionbuffer !== 2'b11) begin
      errors++;
      $display("[TB] FAIL beq_strong_t: pred=%b ctr=%b want 1/11", predict, predictionbuffer);
    end
    sb.push_back('{"beq_taken_next", 32'h20});
    tick();
    e = sb.pop_front();
    checks++;
    if (imem_addr !== e.value) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", e.tag, imem_addr, e.value);
    end
  endtask

  task automatic test_saturation();
    logic       outcome [13];
    logic [1:0] model;
    for (int i = 0; i < 13; i++) outcome[i] = (i < 5);
    model = 2'b11;
    set_pc(32'h10);
    pc_write = 1'b0; ins = BEQ;
    for (int i = 0; i < 13; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = outcome[i];
      if (outcome[i]) model = (model == 2'b11) ? 2'b11 : model + 2'd1;
      else            model = (model == 2'b00) ? 2'b00 : model - 2'd1;
      tick();
      upd_valid = 1'b0;
      #1;
      checks++;
      if (predictionbuffer !== model || predict !== model[1]) begin
        errors++;
        $display("[TB] FAIL sat_step%0d: ctr=%b pred=%b want %b/%b",
                 i, predictionbuffer, predict, model, model[1]);
      end
    end
    pc_write = 1'b1; ins = NOP;
  endtask

  task automatic test_stall_redirect();
    ins = NOP; pc_write = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    sb.push_back('{"redirect_over_stall", 32'h40});
    tick();
    redirect_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (imem_addr !== e.value) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", e.tag, imem_addr, e.value);
    end
    for (int i = 0; i < 3; i++) sb.push_back('{"stall_hold", 32'h40});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (imem_addr !== e.value) begin
        errors++;
        $display("[TB] FAIL %s%0d: got %h want %h", e.tag, i, imem_addr, e.value);
      end
    end
    pc_write = 1'b1;
  endtask

  task automatic test_jump_wrap();
    set_pc(32'h1000_0000);
    ins = JMP;
    sb.push_back('{"jump_target", 32'h1000_0040});
    tick();
    e = sb.pop_front();
    checks++;
    if (imem_addr !== e.value) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", e.tag, imem_addr, e.value);
    end
    ins = NOP;
    set_pc(32'hFFFF_FFFC);
    #1;
    checks++;
    if (pcaddr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pcaddr: got %h want 00000000", pcaddr);
    end
    sb.push_back('{"wrap_next", 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (imem_addr !== e.value) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", e.tag, imem_addr, e.value);
    end
  endtask

  task automatic test_same_cycle_update();
    logic [1:0] want;
`ifdef IF_BHT_FWD_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    set_pc(32'h80);
    pc_write = 1'b0; ins = NOP;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
    #1;
    checks++;
    if (predictionbuffer !== want) begin
      errors++;
      $display("[TB] FAIL same_cycle_read: ctr=%b want %b", predictionbuffer, want);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++;
    if (predictionbuffer !== 2'b10) begin
      errors++;
      $display("[TB] FAIL same_cycle_landed: ctr=%b want 10", predictionbuffer);
    end
    pc_write = 1'b1;
  endtask

  task automatic test_mid_reset();
    pc_write = 1'b1; ins = NOP;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: got %h want 00000000", imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h0 || predictionbuffer !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_reset_hold: addr=%h ctr=%b want 0/01", imem_addr, predictionbuffer);
    end
    redirect_valid = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    set_pc(32'h10);
    #1;
    checks++;
    if (predictionbuffer !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_reset_ctr_idx4: got %b want 01", predictionbuffer);
    end
    set_pc(32'h80);
    #1;
    checks++;
    if (predictionbuffer !== 2'b01) begin
      errors++;
      $display("[TB] FAIL mid_reset_ctr_idx32: got %b want 01", predictionbuffer);
    end
  endtask

  initial begin
    test_reset();
    test_branch_predict();
    test_saturation();
    test_stall_redirect();
    test_jump_wrap();
    test_same_cycle_update();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
